// File: rtl/l2_cache_pkg.sv
// Shared L2 constants and the way-read sequencer state encoding.
package l2_cache_pkg;
  localparam int WAYS      = 8;
  localparam int SEL_BITS  = 3;
  localparam int LINE_BITS = 512;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    STREAM = 2'd2
  } seq_state_e;
endpackage

// File: rtl/onehot_way_encoder.sv
// Hit vector -> way index, plus no-hit and multi-hit flags. Purely combinational.
module onehot_way_encoder
  import l2_cache_pkg::*;
(
  input  logic [WAYS-1:0]     hit_vec,
  output logic [SEL_BITS-1:0] idx,
  output logic                none,
  output logic                multi
);

  // OR-reduce the indices of set bits; exact only when the vector is one-hot,
  // which is the only case in which idx is consumed.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WAYS; i++)
      if (hit_vec[i]) idx = idx | SEL_BITS'(i);
  end

  assign none  = ~|hit_vec;
  // Clearing the lowest set bit leaves something behind iff >1 bit was set.
  assign multi = |(hit_vec & (hit_vec - WAYS'(1)));

endmodule

// File: rtl/l2_way_read_sequencer.sv
// Classifies a lookup result, selects the hit way, captures the line and
// streams it out as eight beats, critical beat first.
module l2_way_read_sequencer
  import l2_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WAYS-1:0]      req_hit_vec,
  input  logic [SEL_BITS-1:0]  req_offset,
  output logic [SEL_BITS-1:0]  way_select,
  input  logic [LINE_BITS-1:0] line_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BEAT_BITS-1:0] rsp_data,
  output logic [SEL_BITS-1:0]  rsp_beat,
  output logic                 rsp_last,
  output logic                 miss,
  output logic                 err_multi_hit
);

  seq_state_e           state;
  logic [LINE_BITS-1:0] line_buf;
  logic [SEL_BITS-1:0]  beat_cnt;
  logic [SEL_BITS-1:0]  offset_q;
  logic [SEL_BITS-1:0]  enc_idx;
  logic                 enc_none;
  logic                 enc_multi;

  onehot_way_encoder u_enc (
    .hit_vec (req_hit_vec),
    .idx     (enc_idx),
    .none    (enc_none),
    .multi   (enc_multi)
  );

  assign req_ready = (state == IDLE);
  assign rsp_beat  = beat_cnt;
  // beat_cnt and line_buf only move on a transfer, so data/last hold while stalled.
  assign rsp_data  = line_buf[{beat_cnt, 6'd0} +: BEAT_BITS];
  // Eighth beat is the one just before the critical beat (mod 8).
  assign rsp_last  = rsp_valid && (beat_cnt == offset_q - 3'd1);

  // Sequencer FSM: accept/classify, one-cycle line capture, then beat streaming.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      way_select    <= '0;
      offset_q      <= '0;
      beat_cnt      <= '0;
      line_buf      <= '0;
      rsp_valid     <= 1'b0;
      miss          <= 1'b0;
      err_multi_hit <= 1'b0;
    end else begin
      miss          <= 1'b0;
      err_multi_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (enc_none)       miss          <= 1'b1;
            else if (enc_multi) err_multi_hit <= 1'b1;
            else begin
              way_select <= enc_idx;
              offset_q   <= req_offset;
              state      <= SELECT;
            end
          end
        end
        SELECT: begin
          line_buf  <= line_in;
          beat_cnt  <= offset_q;
          rsp_valid <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              rsp_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_way_read_sequencer.sv
// Bench for l2_way_read_sequencer: directed and randomized lines checked
// against a queue-based model of the expected beat order.
module tb_l2_way_read_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [7:0]   req_hit_vec = '0;
  logic [2:0]   req_offset = '0;
  logic [2:0]   way_select;
  logic [511:0] line_in;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [63:0]  rsp_data;
  logic [2:0]   rsp_beat;
  logic         rsp_last;
  logic         miss;
  logic         err_multi_hit;

  logic [511:0] lines [8];
  int errors = 0;
  int checks = 0;

  // External 8:1 line mux
  assign line_in = lines[way_select];

  always #5 clk = ~clk;

  l2_way_read_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_hit_vec   (req_hit_vec),
    .req_offset    (req_offset),
    .way_select    (way_select),
    .line_in       (line_in),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_beat      (rsp_beat),
    .rsp_last      (rsp_last),
    .miss          (miss),
    .err_multi_hit (err_multi_hit)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random_lines();
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 16; k++)
        lines[w][k*32 +: 32] = $urandom;
  endtask

  // Called and returns at a negedge. mode 0: always ready, 1: alternate 0/1, 2: random.
  task automatic stream_line(input logic [7:0] hit, input logic [2:0] off, input int mode);
    int way;
    int q[$];
    int ncyc;
    int nxfer;
    logic rdy;
    logic alt;
    way = 0;
    for (int i = 0; i < 8; i++) if (hit[i]) way = i;
    for (int k = 0; k < 8; k++) q.push_back((int'(off) + k) % 8);
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_hit_vec = hit; req_offset = off;
    @(negedge clk);
    req_valid = 1'b0;
    chk("way_select_t1", way_select, 64'(way));
    chk("req_ready_t1", req_ready, 0);
    chk("rsp_valid_t1", rsp_valid, 0);
    chk("miss_t1", miss, 0);
    @(negedge clk);
    ncyc = 0; nxfer = 0; alt = 1'b0;
    while (q.size() > 0 && ncyc < 64) begin
      int b;
      logic [511:0] ln;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? alt : 1'($urandom % 2);
      alt = ~alt;
      rsp_ready = rdy;
      b = q[0];
      ln = lines[way];
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_beat", rsp_beat, 64'(b));
      chk("rsp_data", rsp_data, ln[b*64 +: 64]);
      chk("rsp_last", rsp_last, (q.size() == 1) ? 1 : 0);
      chk("way_select_hold", way_select, 64'(way));
      if (rdy) begin void'(q.pop_front()); nxfer++; end
      ncyc++;
      @(negedge clk);
    end
    chk("stream_timeout", 64'(q.size()), 0);
    chk("transfers", 64'(nxfer), 8);
    if (mode == 0) chk("stream_cycles", 64'(ncyc), 8);
    chk("rsp_valid_after", rsp_valid, 0);
    chk("req_ready_after", req_ready, 1);
    rsp_ready = 1'b1;
  endtask

  initial begin
    fill_random_lines();
    for (int k = 0; k < 8; k++) lines[5][k*64 +: 64] = 64'(k * 16);

    // 1: reset held two cycles
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_way_select", way_select, 0);
    chk("rst_miss", miss, 0);
    chk("rst_err", err_multi_hit, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_beat", rsp_beat, 0);
    chk("rst_rsp_last", rsp_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: way 5, offset 0, always ready
    stream_line(8'b0010_0000, 3'd0, 0);
    // 3: way 2, offset 6 (wraps)
    stream_line(8'b0000_0100, 3'd6, 0);
    // 4: way 5, offset 0, alternating ready
    stream_line(8'b0010_0000, 3'd0, 1);

    // 5: miss and multi-hit pulses
    req_valid = 1'b1; req_hit_vec = 8'h00; req_offset = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("miss_pulse", miss, 1);
    chk("miss_no_err", err_multi_hit, 0);
    chk("miss_no_rsp", rsp_valid, 0);
    chk("miss_ready", req_ready, 1);
    chk("miss_way_hold", way_select, 5);
    @(negedge clk);
    chk("miss_one_cycle", miss, 0);
    chk("miss_no_rsp2", rsp_valid, 0);
    req_valid = 1'b1; req_hit_vec = 8'b0010_0100;
    @(negedge clk);
    req_valid = 1'b0;
    chk("multi_pulse", err_multi_hit, 1);
    chk("multi_no_miss", miss, 0);
    chk("multi_no_rsp", rsp_valid, 0);
    chk("multi_ready", req_ready, 1);
    chk("multi_way_hold", way_select, 5);
    @(negedge clk);
    chk("multi_one_cycle", err_multi_hit, 0);
    chk("multi_no_rsp2", rsp_valid, 0);

    // 6: reset after the third beat of a stream
    fill_random_lines();
    req_valid = 1'b1; req_hit_vec = 8'b1000_0000; req_offset = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("pre_rst_beat", rsp_beat, 64'((1 + k) % 8));
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_way_select", way_select, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_rsp_valid", rsp_valid, 0);
    stream_line(8'b0000_1000, 3'd4, 0);

    // Randomized lines: random way, offset and backpressure
    for (int n = 0; n < 10; n++) begin
      fill_random_lines();
      stream_line(8'(1 << $urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
